// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: VGA sync timing monitor, pixel extractor and lock FSM.
// Define FRAME_CHECKSUM_EN to enable the per-frame pixel checksum.
module vga_sync_monitor #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_ACT   = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_ACT   = 480,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        r_in,
  input  logic        g_in,
  input  logic        b_in,
  output logic        de,
  output logic [9:0]  x_pos,
  output logic [8:0]  y_pos,
  output logic        r_q,
  output logic        g_q,
  output logic        b_q,
  output logic        frame_start,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [15:0] frame_sum,
  output logic        sum_valid
);

  localparam logic [9:0] CMAX = '1;
  localparam logic [9:0] H_LO = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_HI = 10'(H_SYNC + H_BACK + H_ACT - 1);
  localparam logic [9:0] V_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_HI = 10'(V_SYNC + V_BACK + V_ACT - 1);
  localparam logic [9:0] H_END = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_END = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW = 10'(H_SYNC);
  localparam logic [9:0] V_SW = 10'(V_SYNC);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  state_t st, st_nxt;

  logic       s_vld;
  logic       hs_s, vs_s;
  logic       hs_p, vs_p;
  logic [2:0] rgb_s;

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_low, v_low;
  logic       h_seen;
  logic       armed;
  logic       bad, bad_nxt;

  logic       adv;
  logic       h_fall, v_fall;
  logic [9:0] h_inc, v_inc;
  logic [9:0] h_nxt, v_nxt;
  logic       h_sat, v_sat;
  logic       line_bad, frm_bad;
  logic       h_err_n, v_err_n;
  logic       de_n;

  // Input sample register plus one sample of sync history for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_vld <= 1'b0;
      hs_s  <= 1'b1;
      vs_s  <= 1'b1;
      hs_p  <= 1'b1;
      vs_p  <= 1'b1;
      rgb_s <= '0;
    end else if (pix_ce) begin
      s_vld <= 1'b1;
      hs_p  <= hs_s;
      vs_p  <= vs_s;
      hs_s  <= h_sync;
      vs_s  <= v_sync;
      rgb_s <= {r_in, g_in, b_in};
    end
  end

  // Next counter values and timing checks for the registered sample.
  always_comb begin
    adv    = pix_ce & s_vld;
    h_fall = hs_p & ~hs_s;
    v_fall = vs_p & ~vs_s;
    h_inc  = (h_cnt == CMAX) ? CMAX : h_cnt + 10'd1;
    v_inc  = (v_cnt == CMAX) ? CMAX : v_cnt + 10'd1;
    h_nxt  = h_fall ? '0 : h_inc;
    if (v_fall)
      v_nxt = '0;
    else if (h_fall)
      v_nxt = v_inc;
    else
      v_nxt = v_cnt;
    h_sat = ~h_fall & (h_cnt == CMAX - 10'd1);
    v_sat = ~v_fall & h_fall
          & (v_cnt == CMAX - 10'd1);
    line_bad = h_fall & h_seen & armed
             & ((h_cnt != H_END) | (h_low != H_SW));
    frm_bad = v_fall & armed
            & ((v_cnt != V_END) | (v_low != V_SW));
    h_err_n = line_bad | h_sat;
    v_err_n = frm_bad;
    de_n = (h_nxt >= H_LO) & (h_nxt <= H_HI)
         & (v_nxt >= V_LO) & (v_nxt <= V_HI);
  end

  // Position counters, sync-width counters and check arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      h_low  <= '0;
      v_low  <= '0;
      h_seen <= 1'b0;
      armed  <= 1'b0;
    end else if (adv) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (h_fall)
        h_low <= 10'd1;
      else if (~hs_s && h_low != CMAX)
        h_low <= h_low + 10'd1;
      if (v_fall)
        v_low <= {9'd0, h_fall};
      else if (~vs_s && h_fall && v_low != CMAX)
        v_low <= v_low + 10'd1;
      if (h_sat)
        h_seen <= 1'b0;
      else if (h_fall)
        h_seen <= 1'b1;
      if (v_sat)
        armed <= 1'b0;
      else if (v_fall)
        armed <= 1'b1;
    end
  end

  // Lock FSM state and per-frame error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= SEARCH;
      bad <= 1'b0;
    end else if (adv) begin
      st  <= st_nxt;
      bad <= bad_nxt;
    end
  end

  // Lock FSM next state; sync loss overrides everything.
  always_comb begin
    st_nxt  = st;
    bad_nxt = bad;
    if (v_fall)
      bad_nxt = 1'b0;
    else if (h_err_n)
      bad_nxt = 1'b1;
    unique case (st)
      SEARCH: begin
        if (v_fall)
          st_nxt = VERIFY;
      end
      VERIFY: begin
        if (v_fall && !bad && !h_err_n && !v_err_n)
          st_nxt = LOCKED;
      end
      LOCKED: begin
        if (h_err_n || v_err_n)
          st_nxt = SEARCH;
      end
      default: st_nxt = SEARCH;
    endcase
    if (h_sat || v_sat)
      st_nxt = SEARCH;
  end

  assign locked = (st == LOCKED);

  // Registered pixel outputs and single-cycle event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b0;
      x_pos       <= '0;
      y_pos       <= '0;
      r_q         <= 1'b0;
      g_q         <= 1'b0;
      b_q         <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      if (adv) begin
        de          <= de_n;
        x_pos       <= de_n ? h_nxt - H_LO : '0;
        y_pos       <= de_n ? 9'(v_nxt - V_LO) : '0;
        r_q         <= de_n & rgb_s[2];
        g_q         <= de_n & rgb_s[1];
        b_q         <= de_n & rgb_s[0];
        frame_start <= v_fall;
        h_err       <= h_err_n;
        v_err       <= v_err_n;
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] acc;

  // Accumulate active pixel colours; publish at each frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      frame_sum <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (adv) begin
        if (v_fall) begin
          frame_sum <= acc;
          sum_valid <= 1'b1;
          acc <= de_n ? {13'd0, rgb_s} : '0;
        end else if (de_n) begin
          acc <= acc + {13'd0, rgb_s};
        end
      end
    end
  end
`else
  assign frame_sum = '0;
  assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed bench for vga_sync_monitor.
// Uses a reduced 20x10 timing so full frames stay short.
module tb_vga_sync_monitor;

  localparam int HS = 4;
  localparam int HB = 3;
  localparam int HA = 8;
  localparam int HT = 20;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VA = 4;
  localparam int VT = 10;

`ifdef FRAME_CHECKSUM_EN
  localparam int SUM_W = 224;
  localparam int SUM_R = 128;
  localparam int SV2   = 2;
`else
  localparam int SUM_W = 0;
  localparam int SUM_R = 0;
  localparam int SV2   = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic        h_sync, v_sync;
  logic        r_in, g_in, b_in;
  logic        de;
  logic [9:0]  x_pos;
  logic [8:0]  y_pos;
  logic        r_q, g_q, b_q;
  logic        frame_start, locked;
  logic        h_err, v_err;
  logic [15:0] frame_sum;
  logic        sum_valid;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_herr = 0, n_verr = 0;
  int n_sv = 0, n_fs = 0, n_leak = 0;
  int lk_herr = -1, lk_verr = -1;
  int lock_cyc = -1;
  logic lk_d = 1'b0;
  int de_rgb = 0;
  logic arm = 1'b0;
  logic got = 1'b0;
  int de_cnt = 0, f_cyc = -1;
  int fx = -1, fy = -1, mx = 0, my = 0;
  int t_start = 0, t_act = 0;
  int h0, v0, e0;

  vga_sync_monitor #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .h_sync(h_sync), .v_sync(v_sync),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .de(de), .x_pos(x_pos), .y_pos(y_pos),
    .r_q(r_q), .g_q(g_q), .b_q(b_q),
    .frame_start(frame_start), .locked(locked),
    .h_err(h_err), .v_err(v_err),
    .frame_sum(frame_sum), .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder; all comparisons live in the initial block.
  always @(negedge clk) begin
    if (h_err) begin
      n_herr  <= n_herr + 1;
      lk_herr <= int'(locked);
    end
    if (v_err) begin
      n_verr  <= n_verr + 1;
      lk_verr <= int'(locked);
    end
    if (sum_valid) n_sv <= n_sv + 1;
    if (frame_start) n_fs <= n_fs + 1;
    if (locked && !lk_d) lock_cyc <= cyc;
    lk_d <= locked;
    if (!de && (x_pos != 0 || y_pos != 0 || {r_q, g_q, b_q} != 0))
      n_leak <= n_leak + 1;
    if (de) de_rgb <= int'({r_q, g_q, b_q});
    if (!arm) begin
      got <= 1'b0;
      de_cnt <= 0;
      mx <= 0;
      my <= 0;
    end else if (de) begin
      de_cnt <= de_cnt + 1;
      if (!got) begin
        got <= 1'b1;
        f_cyc <= cyc;
        fx <= int'(x_pos);
        fy <= int'(y_pos);
      end
      if (int'(x_pos) > mx) mx <= int'(x_pos);
      if (int'(y_pos) > my) my <= int'(y_pos);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic hs, input logic vs,
                      input logic [2:0] c);
    h_sync = hs;
    v_sync = vs;
    {r_in, g_in, b_in} = c;
    @(posedge clk);
    #1;
  endtask

  // One frame of ideal timing; long_line gets one extra pixel,
  // max_s >= 0 stops after that many samples.
  task automatic run_frame(input int lines, input int long_line,
                           input logic [2:0] col, input int max_s);
    int cnt = 0;
    for (int l = 0; l < lines; l++) begin
      for (int i = 0; i < HT + ((l == long_line) ? 1 : 0); i++) begin
        if (max_s >= 0 && cnt >= max_s) return;
        if (l == 0 && i == 0) t_start = cyc;
        if (l == VS + VB && i == HS + HB) t_act = cyc;
        tick((i < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, col);
        cnt++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pix_ce = 1'b1;
    h_sync = 1'b1;
    v_sync = 1'b1;
    {r_in, g_in, b_in} = 3'b000;
    repeat (3) tick(1'b1, 1'b1, 3'b111);
    chk("rst_outs", int'({de, x_pos, y_pos, r_q, g_q, b_q,
        frame_start, h_err, v_err, sum_valid}), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_sum", int'(frame_sum), 0);
    rst = 1'b0;

    arm = 1'b1;
    run_frame(VT, -1, 3'b111, -1);
    chk("f1_latency", f_cyc - t_act, 2);
    chk("f1_first_x", fx, 0);
    chk("f1_first_y", fy, 0);
    chk("f1_last_x", mx, HA - 1);
    chk("f1_last_y", my, VA - 1);
    chk("f1_de_count", de_cnt, HA * VA);
    chk("f1_locked", int'(locked), 0);
    chk("f1_fstart", n_fs, 1);
    arm = 1'b0;

    run_frame(VT, -1, 3'b111, -1);
    chk("f2_lock_lat", lock_cyc - t_start, 2);
    chk("f2_locked", int'(locked), 1);
    chk("f2_sum_white", int'(frame_sum), SUM_W);
    chk("f2_sum_valid", n_sv, SV2);
    chk("f2_h_err", n_herr, 0);
    chk("f2_v_err", n_verr, 0);

    run_frame(VT, -1, 3'b100, -1);
    chk("f3_rgb", de_rgb, 4);
    chk("f3_locked", int'(locked), 1);

    h0 = n_herr;
    run_frame(VT, 5, 3'b111, -1);
    chk("long_h_err", n_herr - h0, 1);
    chk("long_lk_at_err", lk_herr, 0);
    chk("long_locked", int'(locked), 0);
    chk("f3_sum_red", int'(frame_sum), SUM_R);

    run_frame(VT, -1, 3'b111, -1);
    chk("relock_f1", int'(locked), 0);
    run_frame(VT, -1, 3'b111, -1);
    chk("relock_f2", int'(locked), 1);

    v0 = n_verr;
    run_frame(VT - 1, -1, 3'b111, -1);
    run_frame(VT, -1, 3'b111, -1);
    chk("short_v_err", n_verr - v0, 1);
    chk("short_lk_at_err", lk_verr, 0);
    chk("short_locked", int'(locked), 0);

    run_frame(VT, -1, 3'b111, -1);
    run_frame(VT, -1, 3'b111, -1);
    chk("relock_v", int'(locked), 1);

    h0 = n_herr;
    v0 = n_verr;
    repeat (1100) tick(1'b1, 1'b1, 3'b111);
    chk("sat_h_err", n_herr - h0, 1);
    chk("sat_locked", int'(locked), 0);
    run_frame(VT, -1, 3'b111, -1);
    chk("sat_h_err_once", n_herr - h0, 1);
    chk("sat_no_v_err", n_verr - v0, 0);

    run_frame(VT, -1, 3'b111, VS * HT + VB * HT + HB + HS + 2);
    chk("pre_rst_de", int'(de), 1);
    chk("pre_rst_locked", int'(locked), 1);
    chk("pre_rst_xy", int'({x_pos, y_pos}), 0);
    rst = 1'b1;
    tick(1'b1, 1'b1, 3'b111);
    chk("mid_rst_outs", int'({de, x_pos, y_pos, r_q, g_q, b_q,
        frame_start, h_err, v_err, sum_valid}), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_sum", int'(frame_sum), 0);
    rst = 1'b0;

    e0 = n_herr + n_verr;
    run_frame(VT, -1, 3'b111, -1);
    chk("post_rst_f1", int'(locked), 0);
    run_frame(VT, -1, 3'b111, -1);
    chk("post_rst_f2", int'(locked), 1);
    chk("post_rst_errs", n_herr + n_verr - e0, 0);
    chk("no_leak", n_leak, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameters (name, default, meaning):
- H_SYNC, 96, h_sync low width (pixels)
- H_BACK, 48, back porch
- H_ACT, 640, active pixels
- H_TOTAL, 800, pixels per line
- V_SYNC, 2, v_sync low width (lines)
- V_BACK, 33, back porch
- V_ACT, 480, active lines
- V_TOTAL, 525, lines per frame
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- pix_ce  in  1  pixel enable; one pixel sampled per cycle with pix_ce=1
- h_sync  in  1  horizontal sync, active-low
- v_sync  in  1  vertical sync, active-low
- r_in, g_in, b_in  in  1 each  pixel colour
- de  out  1  sample is in active area
- x_pos  out  10  active column 0..639
- y_pos  out  9  active row 0..479
- r_q, g_q, b_q  out  1 each  colour, qualified by de
- frame_start  out  1  one-cycle pulse at v_sync falling edge
- locked  out  1  timing verified
- h_err  out  1  one-cycle pulse, line timing violation
- v_err  out  1  one-cycle pulse, frame timing violation
- frame_sum  out  16  per-frame pixel checksum
- sum_valid  out  1  one-cycle pulse, frame_sum updated

Function
REQ-003 All inputs registered once on pix_ce; edges detected against previous registered value; nothing advances when pix_ce=0.
REQ-004 h_cnt (10 b) = 0 on sample with h_sync falling edge, else +1; saturates at 1023.
REQ-005 v_cnt (10 b) increments on each h_sync falling edge; v_sync falling edge forces 0 (wins if coincident); saturates at 1023.
REQ-006 de=1 iff h_cnt in [H_SYNC+H_BACK, +H_ACT-1] and v_cnt in [V_SYNC+V_BACK, +V_ACT-1]; x_pos=h_cnt-144, y_pos=v_cnt-35 (default params); x_pos/y_pos/rgb_q = 0 when de=0.
REQ-007 Latency: sample presented at pix_ce cycle n appears on de/x_pos/y_pos/*_q at cycle n+2.
REQ-008 Line check, at each h_sync falling edge: previous h_cnt+1 must equal H_TOTAL; h_sync low width must equal H_SYNC; mismatch -> h_err pulse. First edge after reset is not checked.
REQ-009 Frame check, at each v_sync falling edge: line count must equal V_TOTAL; v_sync low width (h_sync edges counted while low) must equal V_SYNC; mismatch -> v_err pulse.
REQ-010 FSM states SEARCH, VERIFY, LOCKED; locked=1 only in LOCKED.
- SEARCH -> VERIFY on first v_sync falling edge.
- VERIFY -> LOCKED on next v_sync falling edge if no h_err/v_err during that frame; else remain VERIFY (restart frame).
- LOCKED -> SEARCH on any h_err, v_err, or h_cnt/v_cnt saturation.
REQ-011 Saturation of h_cnt (sync lost) in any state -> SEARCH, h_err pulse once.
REQ-012 de and pixel outputs produced regardless of locked.

Reset
REQ-013 On rst=1: FSM=SEARCH, counters 0, edge history = 1 (idle sync level), all outputs 0, frame_sum 0.
REQ-014 rst mid-frame discards partial frame; first checks occur only after a new v_sync falling edge.

Configuration
REQ-015 Macro FRAME_CHECKSUM_EN: when defined, frame_sum accumulates (mod 2^16) {r,g,b} as 3-bit value of every de=1 pixel; at v_sync falling edge the total is latched to frame_sum, sum_valid pulses, accumulator clears. When undefined, frame_sum=0 and sum_valid=0 permanently, no accumulator logic.

Verification
REQ-016 Ideal 640x480 timing, pix_ce=1, 3 frames -> locked=1 at second v_sync falling edge, no h_err/v_err.
REQ-017 Solid white input, FRAME_CHECKSUM_EN defined -> frame_sum = 307200*7 mod 65536 = 53248 (0xD000) with sum_valid each frame; undefined -> 0.
REQ-018 While locked, one line of 801 pixels -> h_err pulse, locked=0 same cycle+1, relock after two clean frames.
REQ-019 Frame with 524 lines -> v_err pulse at v_sync edge, FSM leaves LOCKED.
REQ-020 First active pixel (h_cnt=144, v_cnt=35) -> de=1, x_pos=0, y_pos=0 two cycles later; h_cnt=783 -> x_pos=639.
REQ-021 h_sync held high 1100 cycles -> h_err once, locked=0; rst asserted mid-frame -> all outputs 0 next cycle.
